tail_light_controller: RTL and testbench

TAIL_LIGHT_CONTROLLER -- requirements
Module: tail_light_controller

---
 rtl/tail_light_pkg.sv | 28 ++
 rtl/tick_divider.sv | 31 +++
 rtl/tail_light_controller.sv | 106 ++++++++++
 tb/tb_tail_light_controller.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tail_light_pkg.sv
// Shared types and constants for the tail light controller.
//   state_t    : sequencing states of the lamp FSM
//   LAMP_*     : 3-bit lamp bar patterns, bit 0 is the innermost lamp
//   brake_lamp : pattern for a side that is not turning
package tail_light_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    L1      = 4'd1,
    L2      = 4'd2,
    L3      = 4'd3,
    R1      = 4'd4,
    R2      = 4'd5,
    R3      = 4'd6,
    HAZ_ON  = 4'd7,
    HAZ_OFF = 4'd8
  } state_t;

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_1   = 3'b001;
  localparam logic [2:0] LAMP_2   = 3'b011;
  localparam logic [2:0] LAMP_3   = 3'b111;

  function automatic logic [2:0] brake_lamp(input logic brake);
    return brake ? LAMP_3 : LAMP_OFF;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running step timer for the lamp sequencer.
//   clk   : system clock
//   reset : asynchronous active-high reset, clears the count
//   tick  : high for the single cycle in which count == TICK_DIV-1
module tick_divider
  import tail_light_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    tick    = (count_q == LAST);
    count_d = tick ? '0 : count_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/tail_light_controller.sv
// Turn / hazard / brake sequencer for a pair of 3-lamp tail light bars.
//   clk    : system clock
//   reset  : asynchronous active-high reset
//   left   : left-turn request (level)
//   right  : right-turn request (level)
//   hazard : hazard request (level); left+right together also counts as hazard
//   brake  : brake pedal (level), shown on any side not turning
//   L, R   : registered lamp bars, bit 0 innermost
//   busy   : registered, high whenever the FSM is not IDLE
//
// state   | meaning
// --------+------------------------------------------
// IDLE    | no sequence, lamps follow brake
// L1..L3  | left sweep steps 001/011/111
// R1..R3  | right sweep steps 001/011/111
// HAZ_ON  | both bars fully lit, brake ignored
// HAZ_OFF | both bars dark, brake ignored
module tail_light_controller
  import tail_light_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  input  logic       brake,
  output logic [2:0] L,
  output logic [2:0] R,
  output logic       busy
);

  logic   tick;
  logic   hz;
  state_t state_q, state_d;
  logic [2:0] l_q, l_d;
  logic [2:0] r_q, r_d;
  logic   busy_q, busy_d;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    hz      = hazard | (left & right);
    state_d = state_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (hz)         state_d = HAZ_ON;
          else if (left)  state_d = L1;
          else if (right) state_d = R1;
        end
        L1:      state_d = hz ? HAZ_ON : L2;
        L2:      state_d = hz ? HAZ_ON : L3;
        L3:      state_d = hz ? HAZ_ON : IDLE;
        R1:      state_d = hz ? HAZ_ON : R2;
        R2:      state_d = hz ? HAZ_ON : R3;
        R3:      state_d = hz ? HAZ_ON : IDLE;
        HAZ_ON:  state_d = HAZ_OFF;
        HAZ_OFF: state_d = hz ? HAZ_ON : IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Lamps follow the next state so they move on the same edge as the FSM,
    // while brake is picked up on every edge regardless of tick.
    l_d = brake_lamp(brake);
    r_d = brake_lamp(brake);
    case (state_d)
      L1:      l_d = LAMP_1;
      L2:      l_d = LAMP_2;
      L3:      l_d = LAMP_3;
      R1:      r_d = LAMP_1;
      R2:      r_d = LAMP_2;
      R3:      r_d = LAMP_3;
      HAZ_ON:  begin l_d = LAMP_3;   r_d = LAMP_3;   end
      HAZ_OFF: begin l_d = LAMP_OFF; r_d = LAMP_OFF; end
      default: ;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      l_q     <= LAMP_OFF;
      r_q     <= LAMP_OFF;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
    end
  end

  assign L    = l_q;
  assign R    = r_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_tail_light_controller.sv
module tb_tail_light_controller;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       left, right, hazard, brake;
  logic [2:0] L, R;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  tail_light_controller #(.TICK_DIV(TICK_DIV)) dut (
    .clk    (clk),
    .reset  (reset),
    .left   (left),
    .right  (right),
    .hazard (hazard),
    .brake  (brake),
    .L      (L),
    .R      (R),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an activity (idle / left sweep / right sweep / hazard
  // flash) plus a step number; lamp bars are (2^step)-1.
  localparam int M_IDLE = 0, M_LEFT = 1, M_RIGHT = 2, M_HAZ = 3;
  int         m_cnt, m_mode, m_step;
  logic [2:0] m_l, m_r;
  logic       m_busy;

  function automatic logic [2:0] bar(input int n);
    int v;
    v = (1 << n) - 1;
    return v[2:0];
  endfunction

  always @(posedge clk or posedge reset) begin
    bit h;
    if (reset) begin
      m_cnt = 0; m_mode = M_IDLE; m_step = 0;
      m_l = 3'b000; m_r = 3'b000; m_busy = 1'b0;
    end else begin
      h = hazard || (left && right);
      if (m_cnt == TICK_DIV - 1) begin
        m_cnt = 0;
        if (m_mode == M_HAZ) begin
          if (m_step == 1)  m_step = 0;
          else if (h)       m_step = 1;
          else              m_mode = M_IDLE;
        end else if (h) begin
          m_mode = M_HAZ; m_step = 1;
        end else if (m_mode == M_IDLE) begin
          if (left)       begin m_mode = M_LEFT;  m_step = 1; end
          else if (right) begin m_mode = M_RIGHT; m_step = 1; end
        end else begin
          m_step++;
          if (m_step > 3) m_mode = M_IDLE;
        end
      end else begin
        m_cnt++;
      end
      m_l = brake ? 3'b111 : 3'b000;
      m_r = m_l;
      case (m_mode)
        M_LEFT:  m_l = bar(m_step);
        M_RIGHT: m_r = bar(m_step);
        M_HAZ:   begin m_l = bar(3 * m_step); m_r = bar(3 * m_step); end
        default: ;
      endcase
      m_busy = (m_mode != M_IDLE);
    end
  end

  typedef struct {
    logic       lt, rt, hz, bk;
    int         cyc;
    logic [2:0] el, er;
    logic       eb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic lt, rt, hz, bk, input int cyc,
                     input logic [2:0] el, er, input logic eb);
    vec_t v;
    v.lt = lt; v.rt = rt; v.hz = hz; v.bk = bk; v.cyc = cyc;
    v.el = el; v.er = er; v.eb = eb;
    vecs.push_back(v);
  endtask

  initial begin
    left = 0; right = 0; hazard = 0; brake = 1; reset = 1;

    // Cycle counts below are edges after reset release; ticks land on 4,8,12...
    //   lt rt hz bk cyc  L       R       busy
    add(1, 0, 0, 0, 3, 3'b000, 3'b000, 0);   // n=3  before first tick
    add(1, 0, 0, 0, 1, 3'b001, 3'b000, 1);   // n=4  L1
    add(1, 0, 0, 0, 4, 3'b011, 3'b000, 1);   // n=8  L2
    add(1, 0, 0, 0, 4, 3'b111, 3'b000, 1);   // n=12 L3
    add(1, 0, 0, 0, 3, 3'b111, 3'b000, 1);   // n=15 still L3
    add(0, 0, 0, 0, 1, 3'b000, 3'b000, 0);   // n=16 IDLE
    add(1, 1, 0, 0, 4, 3'b111, 3'b111, 1);   // n=20 HAZ_ON
    add(1, 1, 0, 0, 4, 3'b000, 3'b000, 1);   // n=24 HAZ_OFF
    add(1, 1, 0, 0, 4, 3'b111, 3'b111, 1);   // n=28 HAZ_ON
    add(1, 1, 0, 0, 4, 3'b000, 3'b000, 1);   // n=32 HAZ_OFF
    add(0, 0, 0, 1, 3, 3'b000, 3'b000, 1);   // n=35 brake ignored in HAZ_OFF
    add(0, 0, 0, 0, 1, 3'b000, 3'b000, 0);   // n=36 IDLE
    add(0, 0, 0, 1, 1, 3'b111, 3'b111, 0);   // n=37 brake at IDLE, no tick
    add(0, 1, 0, 0, 3, 3'b000, 3'b001, 1);   // n=40 R1
    add(0, 1, 0, 1, 1, 3'b111, 3'b001, 1);   // n=41 brake on idle side
    add(0, 0, 0, 0, 3, 3'b000, 3'b011, 1);   // n=44 R2 despite right dropped
    add(0, 0, 1, 0, 4, 3'b111, 3'b111, 1);   // n=48 hazard preempts, no R3
    add(0, 0, 0, 0, 4, 3'b000, 3'b000, 1);   // n=52 HAZ_OFF
    add(1, 0, 0, 0, 4, 3'b000, 3'b000, 0);   // n=56 IDLE (no hz)
    add(1, 0, 0, 0, 4, 3'b001, 3'b000, 1);   // n=60 L1
    add(1, 0, 0, 0, 4, 3'b011, 3'b000, 1);   // n=64 L2
    add(0, 1, 0, 0, 4, 3'b111, 3'b000, 1);   // n=68 L3 despite switch
    add(0, 1, 0, 0, 4, 3'b000, 3'b000, 0);   // n=72 IDLE
    add(0, 1, 0, 0, 4, 3'b000, 3'b001, 1);   // n=76 R1

    repeat (3) @(negedge clk);
    chk("reset_L", L, 3'b000);
    chk("reset_R", R, 3'b000);
    chk("reset_busy", {2'b00, busy}, 3'b000);
    brake = 0;
    @(negedge clk);
    reset = 0;

    foreach (vecs[i]) begin
      left = vecs[i].lt; right = vecs[i].rt; hazard = vecs[i].hz; brake = vecs[i].bk;
      repeat (vecs[i].cyc) @(negedge clk);
      chk($sformatf("vec%0d_L", i), L, vecs[i].el);
      chk($sformatf("vec%0d_R", i), R, vecs[i].er);
      chk($sformatf("vec%0d_busy", i), {2'b00, busy}, {2'b00, vecs[i].eb});
    end

    // Asynchronous reset between edges while in L3
    left = 0; right = 0; hazard = 0; brake = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    left = 1;
    repeat (13) @(negedge clk);
    chk("async_pre_L", L, 3'b111);
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("async_L", L, 3'b000);
    chk("async_busy", {2'b00, busy}, 3'b000);
    @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_n3_L", L, 3'b000);
    chk("post_rst_n3_busy", {2'b00, busy}, 3'b000);
    @(negedge clk);
    chk("post_rst_n4_L", L, 3'b001);
    chk("post_rst_n4_busy", {2'b00, busy}, 3'b001);

    // Random stimulus against the reference model
    left = 0; right = 0; hazard = 0; brake = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      chk("rand_L", L, m_l);
      chk("rand_R", R, m_r);
      chk("rand_busy", {2'b00, busy}, {2'b00, m_busy});
      if ($urandom_range(0, 7) == 0)   left   = ~left;
      if ($urandom_range(0, 7) == 0)   right  = ~right;
      if ($urandom_range(0, 15) == 0)  hazard = ~hazard;
      if ($urandom_range(0, 3) == 0)   brake  = ~brake;
      reset = ($urandom_range(0, 399) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
